// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, tag base and requester limit.
// UART_ARB_TAG_EN (when defined) prefixes every data byte with an ASCII requester tag.
package uart_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam logic [7:0] TAG_BASE = 8'h30;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_START     = 2'd1,
    ARB_WAIT_BUSY = 2'd2,
    ARB_WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first valid requester searched upward from last+1,
// wrapping modulo NUM_REQ.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any
);

  // Walk offsets from the farthest down to the nearest so the nearest valid index wins.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART serializer among NUM_REQ byte producers.
// Define UART_ARB_TAG_EN to send an ASCII tag frame ('0'+grant_id) before each data byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 active
);

  localparam logic [1:0] S_IDLE      = ARB_IDLE;
  localparam logic [1:0] S_START     = ARB_START;
  localparam logic [1:0] S_WAIT_BUSY = ARB_WAIT_BUSY;
  localparam logic [1:0] S_WAIT_DONE = ARB_WAIT_DONE;

  logic [1:0]         state_reg, state_next;
  logic [ID_W-1:0]    last_reg;
  logic [ID_W-1:0]    grant_id_reg;
  logic               active_reg;
  logic [7:0]         tx_data_reg;
  logic [7:0]         req_bytes [NUM_REQ];
  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_id;
  logic               pick_any;
  logic               accept;
  logic               frame_done;
  logic               more_frames;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign req_bytes[gi] = req_data[8*gi +: 8];
  end

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_valid (req_valid),
    .last      (last_reg),
    .grant     (pick_grant),
    .grant_id  (pick_id),
    .any       (pick_any)
  );

  // A grant is only offered while idle and the serializer is quiet.
  assign accept     = (state_reg == S_IDLE) && !tx_busy && pick_any;
  assign frame_done = (state_reg == S_WAIT_DONE) && !tx_busy;
  assign req_ready  = accept ? pick_grant : '0;
  assign tx_start   = (state_reg == S_START);
  assign tx_data    = tx_data_reg;
  assign grant_id   = grant_id_reg;
  assign active     = active_reg;

`ifdef UART_ARB_TAG_EN
  logic       tag_pending_reg;
  logic [7:0] data_hold_reg;

  assign more_frames = tag_pending_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_pending_reg <= 1'b0;
      data_hold_reg   <= 8'h00;
    end else if (accept) begin
      tag_pending_reg <= 1'b1;
      data_hold_reg   <= req_bytes[pick_id];
    end else if (frame_done) begin
      tag_pending_reg <= 1'b0;
    end
  end
`else
  assign more_frames = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (accept) state_next = S_START;
      S_START:     state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: if (tx_busy) state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (!tx_busy) state_next = more_frames ? S_START : S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      last_reg     <= ID_W'(NUM_REQ - 1);
      grant_id_reg <= '0;
      active_reg   <= 1'b0;
      tx_data_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        grant_id_reg <= pick_id;
        last_reg     <= pick_id;
        active_reg   <= 1'b1;
`ifdef UART_ARB_TAG_EN
        tx_data_reg  <= TAG_BASE + 8'(pick_id);
`else
        tx_data_reg  <= req_bytes[pick_id];
`endif
      end
`ifdef UART_ARB_TAG_EN
      // The held data byte replaces the tag once the tag frame has finished.
      if (frame_done && tag_pending_reg) tx_data_reg <= data_hold_reg;
`endif
      if (frame_done && !more_frames) active_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner sequences and a
// randomized run scored against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*8-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           active;

  logic           force_busy = 1'b0;
  logic           rand_busy = 1'b0;
  int             busy_len_cfg = 4;
  int             ser_cnt = 0;

  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;
  int             n_acc = 0;
  int             model_last = N - 1;
  logic           prev_start = 1'b0;
  logic           prev_busy = 1'b0;
  logic           idle_chk = 1'b0;
  logic [N-1:0]   last_ready = '0;

  typedef struct {
    logic [7:0] data;
    int         id;
    int         due;
  } frame_t;
  frame_t exp_q[$];

  typedef struct {
    logic [N-1:0] valid;
    logic [7:0]   base;
    int           busy;
    int           exp_id;
    logic [7:0]   exp_data;
  } vec_t;
  vec_t vecs[8];

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active)
  );

  always #5 clk = ~clk;

  // Serializer model: busy from the cycle after tx_start for a configurable number of cycles.
  always @(posedge clk) begin
    if (reset) ser_cnt <= 0;
    else if (tx_start) ser_cnt <= rand_busy ? int'($urandom_range(12, 1)) : busy_len_cfg;
    else if (ser_cnt != 0) ser_cnt <= ser_cnt - 1;
  end
  assign tx_busy = (ser_cnt != 0) || force_busy;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int rr_pick(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // Transaction-level scoreboard: predicts each grant and the frames it must produce.
  always @(negedge clk) begin
    int w;
    int a;
    frame_t f;
    cyc++;
    if (reset) begin
      exp_q.delete();
      model_last = N - 1;
      prev_start = 1'b0;
      prev_busy  = 1'b0;
      idle_chk   = 1'b0;
      last_ready = '0;
    end else begin
      if (idle_chk) check("active_clear", {31'b0, active}, 32'd0);
      idle_chk = prev_busy && !tx_busy && (exp_q.size() == 0) && active;
      if (req_ready != '0) begin
        n_acc++;
        w = rr_pick(req_valid, model_last);
        a = -1;
        for (int i = N - 1; i >= 0; i--) if (req_ready[i]) a = i;
        check("accept_winner", a, w);
        check("accept_onehot", $countones(req_ready), 1);
        check("accept_cond", {30'b0, tx_busy, active}, 32'd0);
`ifdef UART_ARB_TAG_EN
        exp_q.push_back('{8'(8'h30 + a), a, cyc + 1});
        exp_q.push_back('{req_data[8*a +: 8], a, -1});
`else
        exp_q.push_back('{req_data[8*a +: 8], a, cyc + 1});
`endif
        model_last = a;
      end
      if (tx_start) begin
        check("start_single_cycle", {31'b0, prev_start}, 32'd0);
        if (exp_q.size() == 0) begin
          check("start_unexpected", 32'd1, 32'd0);
        end else begin
          f = exp_q.pop_front();
          check("start_data", tx_data, f.data);
          check("start_grant_id", grant_id, f.id);
          check("start_active", {31'b0, active}, 32'd1);
          if (f.due >= 0) check("start_latency", cyc, f.due);
        end
      end
      prev_start = tx_start;
      prev_busy  = tx_busy;
      last_ready = req_ready;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic wait_accept(output int id);
    id = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int i = N - 1; i >= 0; i--) if (req_ready[i]) id = i;
        return;
      end
    end
    check("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_start();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (tx_start) return;
    end
    check("start_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (!active && !tx_busy && exp_q.size() == 0) return;
    end
    check("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int id;
    int n;
    int order[5];
    order = '{0, 1, 2, 3, 0};
    vecs[0] = '{4'b0100, 8'hA3, 10, 2, 8'hA5};
    vecs[1] = '{4'b1111, 8'h20, 3, 3, 8'h23};
    vecs[2] = '{4'b1111, 8'h40, 1, 0, 8'h40};
    vecs[3] = '{4'b0011, 8'h50, 5, 1, 8'h51};
    vecs[4] = '{4'b0001, 8'h60, 2, 0, 8'h60};
    vecs[5] = '{4'b1000, 8'hF0, 7, 3, 8'hF3};
    vecs[6] = '{4'b0110, 8'h00, 4, 1, 8'h01};
    vecs[7] = '{4'b0101, 8'h7C, 6, 2, 8'h7E};

    // Reset values.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_active", active, 0);

    // Serializer busy across reset release: no grant until it drops.
    @(posedge clk); #1 reset = 1'b1; force_busy = 1'b1;
    @(posedge clk); #1 reset = 1'b0; req_valid = 4'b0001; req_data[7:0] = 8'h42;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      check("busy_hold_no_grant", req_ready, 0);
    end
    @(posedge clk); #1 force_busy = 1'b0;
    @(negedge clk);
    check("busy_release_grant", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = '0;
    wait_idle();

    // Vector table, applied from a fresh reset so the pointer starts at NUM_REQ-1.
    do_reset();
    for (int r = 0; r < 8; r++) begin
      @(posedge clk); #1;
      busy_len_cfg = vecs[r].busy;
      req_valid = vecs[r].valid;
      for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'(vecs[r].base + 8'(i));
      wait_accept(id);
      check("row_grant", id, vecs[r].exp_id);
      @(posedge clk); #1 req_valid = '0;
`ifdef UART_ARB_TAG_EN
      wait_start();
      check("row_tag", tx_data, 8'(8'h30 + 8'(vecs[r].exp_id)));
`endif
      wait_start();
      check("row_data", tx_data, vecs[r].exp_data);
      check("row_grant_id", grant_id, vecs[r].exp_id);
      wait_idle();
      $display("row %0d: valid=%b granted %0d byte %0h", r, vecs[r].valid, id, vecs[r].exp_data);
    end

    // All four requesters continuously valid: strict rotation 0,1,2,3,0.
    do_reset();
    @(posedge clk); #1;
    busy_len_cfg = 4;
    req_data = 32'h13121110;
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_accept(id);
      check("rotate_order", id, order[g]);
    end
    @(posedge clk); #1 req_valid = '0;
    wait_idle();

    // Requester 1 withdraws before the arbiter returns to idle; requester 2 must win.
    @(posedge clk); #1;
    busy_len_cfg = 8;
    req_data = 32'h33222211;
    req_valid = 4'b1000;
    wait_accept(id);
    check("drop_first_grant", id, 3);
    @(posedge clk); #1 req_valid = 4'b0110;
    @(posedge clk); #1 req_valid = 4'b0100;
    wait_accept(id);
    check("drop_second_grant", id, 2);
    @(posedge clk); #1 req_valid = '0;
    wait_idle();

    // Reset while a frame is in flight: nothing further is sent, pointer restarts.
    @(posedge clk); #1;
    busy_len_cfg = 10;
    req_data = 32'h00550000;
    req_valid = 4'b0100;
    wait_accept(id);
    @(posedge clk); #1 req_valid = '0;
    wait_start();
    for (int t = 0; t < 50 && !tx_busy; t++) @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_tx_start", tx_start, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_grant_id", grant_id, 0);
    check("midrst_active", active, 0);
    check("midrst_tx_busy", tx_busy, 0);
    n = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (tx_start) n++;
    end
    check("midrst_no_start", n, 0);
    @(posedge clk); #1;
    busy_len_cfg = 3;
    req_data = 32'h99000088;
    req_valid = 4'b1001;
    wait_accept(id);
    check("midrst_fresh_grant", id, 0);
    @(posedge clk); #1 req_valid = '0;
    wait_idle();

    // Randomized traffic against the scoreboard.
    rand_busy = 1'b1;
    n = n_acc;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && last_ready[i]) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(3) == 0) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end else if (req_valid[i] && $urandom_range(49) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    @(posedge clk); #1 req_valid = '0;
    wait_idle();
    check("rand_enough_traffic", (n_acc - n) > 50, 1);
    check("rand_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single UART transmitter in the LED/UART top among up to `NUM_REQ` byte producers (LED counter reporter, status sources, debug taps). It accepts one byte at a time from requesters over a valid/ready handshake, sequences the downstream transmitter through its start/busy handshake, and guarantees that each frame finishes before the next one is issued. It sits between the requesters and the UART TX serializer, inside the top wrapper.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of `grant_id`.
- `clk`  in  1  system clock, single domain.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester byte-valid.
- `req_data`  in  NUM_REQ*8  byte of requester i in bits [8i+7:8i].
- `req_ready`  out  NUM_REQ  one-hot accept strobe, at most one bit high per cycle.
- `tx_data`  out  8  byte presented to the serializer.
- `tx_start`  out  1  single-cycle start pulse to the serializer.
- `tx_busy`  in  1  serializer busy, high while a frame is shifting.
- `grant_id`  out  ID_W  index of the requester currently being served.
- `active`  out  1  high from accept until the last frame of the transaction completes.

## Operation
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE: if any `req_valid` and `tx_busy`==0, the winner is the first valid index searched from `last+1` mod NUM_REQ upward. `req_ready[winner]` is driven combinationally in the same cycle. At the clock edge, the block latches `req_data[winner]` and sets `grant_id`, `last`, and `active`. Next state: START.
- START: `tx_start`=1 for exactly one cycle. `tx_data` holds the current byte. Next state: WAIT_BUSY.
- WAIT_BUSY: stays until `tx_busy`==1, then moves to WAIT_DONE. No timeout.
- WAIT_DONE: stays until `tx_busy`==0. If a second byte of the transaction is pending (tag mode), the next state is START with that byte. Otherwise the next state is IDLE and `active` is cleared.
- Round-robin pointer `last` resets to NUM_REQ-1, so requester 0 has priority first.
- Valid/ready rule: a requester holds `req_valid` and its data stable until it sees `req_ready`. The byte is transferred in the cycle where both are high. `req_ready` is never high outside IDLE.
- Requesters whose `req_valid` drops before grant are ignored; nothing is queued.
- `tx_busy` high while in IDLE (serializer still finishing or externally driven): no grant is issued.
- Simultaneous requests: exactly one is granted per transaction. The others wait at least one full transaction.

## Timing
- Reset values: `req_ready`=0, `tx_start`=0, `tx_data`=8'h00, `grant_id`=0, `active`=0, state=IDLE, `last`=NUM_REQ-1.
- Accept at cycle N; `tx_start` high in cycle N+1; earliest `tx_busy` sample in N+2.
- After `tx_busy` falls at cycle M, the FSM is in IDLE at M+1. It can accept again at M+1 (idle gap of one cycle minimum).
- Reset mid-operation: the FSM returns to IDLE next edge and the in-flight byte or tag is dropped. `tx_start` is never issued after reset. The serializer shares `reset`.

## Configuration
- `UART_ARB_TAG_EN` defined: each transaction sends two frames. The first is the tag byte 8'h30 + `grant_id` (ASCII '0'..'7'), then the data byte. `active` spans both frames.
- Undefined: one frame per transaction (data byte only). No tag logic is synthesized.

## Structure
- Package `uart_arb_pkg`: FSM state enum, `TAG_BASE` = 8'h30, `MAX_REQ` = 8.
- Sub-module `uart_rr_pick`: combinational round-robin picker. Inputs are `req_valid` and `last`; outputs are a one-hot grant, `grant_id`, and `any`. The FSM and registers stay in `uart_tx_arbiter`.

## Test plan
- Single request: `req_valid[2]`=1, data 8'hA5, serializer model busy for 10 cycles → `req_ready[2]` for one cycle, `tx_start` next cycle with `tx_data`=8'hA5, `active` low after busy falls.
- All four valid continuously, data 8'h10..8'h13 → frames issued in order 0,1,2,3,0 with `grant_id` matching; no `req_ready` pulse while `active`=1.
- `tx_busy` held high at reset release, `req_valid[0]`=1 → no grant until `tx_busy` drops; then grant in the following cycle.
- `UART_ARB_TAG_EN` defined, requester 3 sends 8'h7E → two `tx_start` pulses carrying 8'h33 then 8'h7E; single `req_ready[3]` pulse.
- `reset` asserted in WAIT_DONE with tag pending → next cycle all outputs at reset values, no further `tx_start`; a fresh request from requester 0 is granted first.
- Requester 1 drops `req_valid` before IDLE while requester 2 is valid → requester 2 is granted; requester 1 gets no `req_ready`.
